div_unit: RTL and testbench

//  Iterative radix-2 divider for DIV/DIVU, one step per cycle.

---
 rtl/div_unit_pkg.sv | 14 +
 rtl/div_unit_step.sv | 19 +
 rtl/div_unit.sv | 149 ++++++++++++++
 tb/tb_div_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared types for the iterative divider: FSM state encoding and ready codes.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_ON     = 2'b01,
        DIV_BYZERO = 2'b10,
        DIV_END    = 2'b11
    } div_state_t;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference when it does not go negative.
module div_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   partial,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] diff;

    // The true remainder is always below the divisor, so WIDTH bits suffice.
    assign diff     = partial - {1'b0, divisor};
    assign q_bit    = ~diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned divider, one quotient bit per cycle.
// Optional DIV_FAST_PATH_EN: skip iteration when |dividend| < |divisor|.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               div_start,
    input  logic               div_signed,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               div_ready
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + WIDTH'(1)) : v;
    endfunction

    div_state_t         state_q, state_d;
    logic [CW-1:0]      counter_q, counter_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               fast_q, fast_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH-1:0]   step_rem;
    logic               step_q;
    logic [WIDTH-1:0]   quo_next;

    assign mag1     = neg_if(opdata1, div_signed & opdata1[WIDTH-1]);
    assign mag2     = neg_if(opdata2, div_signed & opdata2[WIDTH-1]);
    assign quo_next = {quo_q[WIDTH-2:0], step_q};

    // The dividend shifts out of quo_q MSB-first while quotient bits shift in.
    div_unit_step #(.WIDTH(WIDTH)) u_step (
        .partial  ({rem_q, quo_q[WIDTH-1]}),
        .divisor  (dvs_q),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        fast_d    = fast_q;
        result_d  = result_q;
        ready_d   = DIV_RESULT_NOT_READY;

        case (state_q)
            DIV_FREE: begin
                if (div_start && !annul) begin
                    dvs_d     = mag2;
                    quo_d     = mag1;
                    rem_d     = '0;
                    counter_d = '0;
                    neg_quo_d = div_signed & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                    neg_rem_d = div_signed & opdata1[WIDTH-1];
                    fast_d    = 1'b0;
                    if (opdata2 == '0) begin
                        state_d = DIV_BYZERO;
                    end else begin
`ifdef DIV_FAST_PATH_EN
                        if (mag1 < mag2) begin
                            fast_d  = 1'b1;
                            rem_d   = opdata1;
                            state_d = DIV_BYZERO;
                        end else begin
                            state_d = DIV_ON;
                        end
`else
                        state_d = DIV_ON;
`endif
                    end
                end
            end
            DIV_ON: begin
                rem_d     = step_rem;
                quo_d     = quo_next;
                counter_d = counter_q + CW'(1);
                if (counter_q == CW'(WIDTH - 1)) begin
                    result_d = {neg_if(step_rem, neg_rem_q), neg_if(quo_next, neg_quo_q)};
                    ready_d  = DIV_RESULT_READY;
                    state_d  = DIV_END;
                end
            end
            DIV_BYZERO: begin
                // Also serves the fast path, which parks the signed dividend in rem_q.
                result_d = fast_q ? {rem_q, {WIDTH{1'b0}}} : '0;
                ready_d  = DIV_RESULT_READY;
                state_d  = DIV_END;
            end
            default: begin
                state_d = DIV_FREE;
            end
        endcase

        if (annul) begin
            state_d  = DIV_FREE;
            ready_d  = DIV_RESULT_NOT_READY;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= DIV_FREE;
            counter_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            fast_q    <= 1'b0;
            result_q  <= '0;
            ready_q   <= DIV_RESULT_NOT_READY;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            fast_q    <= fast_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result    = result_q;
    assign div_ready = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit; expected results computed by hand.
module tb_div_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           div_start = 1'b0;
    logic           div_signed = 1'b0;
    logic           annul = 1'b0;
    logic [W-1:0]   opdata1 = '0;
    logic [W-1:0]   opdata2 = '0;
    logic [2*W-1:0] result;
    logic           div_ready;

    int vectors = 0;
    int errs = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_start  (div_start),
        .div_signed (div_signed),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .result     (result),
        .div_ready  (div_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("vector %0d %s: observed %h expected %h", vectors, tag, obs, exp);
    endtask

    // Called just after the sampling edge; counts cycles until div_ready (bounded).
    task automatic wait_ready(input int drop_at, output int n);
        n = 1;
        while (!div_ready && n < 60) begin
            if (n == drop_at) div_start = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s, input logic [63:0] exp_res, input int exp_cyc,
                           input int drop_at);
        int n;
        opdata1    = a;
        opdata2    = b;
        div_signed = s;
        div_start  = 1'b1;
        @(posedge clk);
        #1;
        wait_ready(drop_at, n);
        chk({tag, " ready"}, 64'(div_ready), 64'd1);
        chk({tag, " cycle"}, 64'(n), 64'(exp_cyc));
        chk({tag, " result"}, result, exp_res);
        div_start = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " pulse"}, 64'(div_ready), 64'd0);
        chk({tag, " hold"}, result, exp_res);
    endtask

    initial begin
        int n;
        int seen;
        logic [63:0] last_res;

        #2;
        chk("reset result", result, 64'h0);
        chk("reset ready", 64'(div_ready), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        run_div("divu 100/7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, 0);
        run_div("div -7/2", 32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 0);
        run_div("div ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, 33, 0);
        run_div("divu 5/0", 32'd5, 32'd0, 1'b0, 64'h0, 2, 0);
        run_div("div 7/-2", 32'd7, 32'hFFFFFFFE, 1'b1, {32'd1, 32'hFFFFFFFD}, 33, 0);
        run_div("divu max/1", 32'hFFFFFFFF, 32'd1, 1'b0, {32'h0, 32'hFFFFFFFF}, 33, 0);
        last_res = {32'h0, 32'hFFFFFFFF};

        // Abort an in-flight divide, then confirm it never delivers.
        opdata1 = 32'd1000; opdata2 = 32'd7; div_signed = 1'b0; div_start = 1'b1;
        @(posedge clk);
        #1;
        repeat (10) @(posedge clk);
        #1;
        annul = 1'b1;
        div_start = 1'b0;
        @(posedge clk);
        #1;
        annul = 1'b0;
        chk("annul ready", 64'(div_ready), 64'd0);
        chk("annul result", result, last_res);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (div_ready) seen = 1;
        end
        chk("annul no late ready", 64'(seen), 64'd0);
        run_div("divu 9/3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, 0);

        // Back-to-back: start stays high; second operands swapped in during END.
        opdata1 = 32'd20; opdata2 = 32'd6; div_signed = 1'b0; div_start = 1'b1;
        @(posedge clk);
        #1;
        wait_ready(0, n);
        chk("b2b first cycle", 64'(n), 64'd33);
        chk("b2b first result", result, {32'd2, 32'd3});
        opdata1 = 32'd21; opdata2 = 32'd4;
        @(posedge clk);
        #1;
        wait_ready(0, n);
        chk("b2b second ready", 64'(div_ready), 64'd1);
        chk("b2b second cycle", 64'(n), 64'd34);
        chk("b2b second result", result, {32'd1, 32'd5});
        div_start = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b pulse", 64'(div_ready), 64'd0);

        run_div("divu drop start", 32'd1000, 32'd7, 1'b0, {32'd6, 32'd142}, 33, 5);

        // Asynchronous reset in the middle of a divide.
        opdata1 = 32'd100; opdata2 = 32'd7; div_signed = 1'b0; div_start = 1'b1;
        @(posedge clk);
        #1;
        repeat (15) @(posedge clk);
        #3;
        div_start = 1'b0;
        resetn = 1'b0;
        #1;
        chk("async reset result", result, 64'h0);
        chk("async reset ready", 64'(div_ready), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_div("post reset 100/7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, 0);

`ifdef DIV_FAST_PATH_EN
        run_div("fast divu 5/9", 32'd5, 32'd9, 1'b0, {32'd5, 32'd0}, 2, 0);
        run_div("fast div -3/5", 32'hFFFFFFFD, 32'd5, 1'b1, {32'hFFFFFFFD, 32'd0}, 2, 0);
`else
        run_div("divu 5/9", 32'd5, 32'd9, 1'b0, {32'd5, 32'd0}, 33, 0);
        run_div("div -3/5", 32'hFFFFFFFD, 32'd5, 1'b1, {32'hFFFFFFFD, 32'd0}, 33, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
